// File: rtl/ysyx_22041211_mem_arbiter.sv
// ============================================================================
// ysyx_22041211_mem_arbiter
//
// Purpose
//   Shares one data-memory port between the instruction fetch unit (read-only)
//   and the load/store unit. The LSU always has priority over the IFU. Only one
//   transaction is in flight at a time:
//       IDLE -> REQ -> WAIT -> RESP -> IDLE
//   A 1-bit owner register records which requester was granted. The response
//   is routed back to that requester.
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   ifu_req_valid/ready      IFU request handshake
//   ifu_raddr                IFU fetch address
//   ifu_resp_valid           one-cycle pulse when ifu_rdata is valid
//   ifu_rdata, ifu_resp_err  IFU response data and timeout flag
//   lsu_req_valid/ready      LSU request handshake
//   lsu_wen                  1 = store, 0 = load
//   lsu_addr, lsu_wdata      LSU address and store data
//   lsu_mask                 LSU byte mask
//   lsu_resp_valid           one-cycle pulse when the load data is valid or
//                            the store is done
//   lsu_rdata, lsu_resp_err  LSU response data (0 for stores) and timeout flag
//   mem_req_valid/ready      memory request handshake; mem_* is held stable
//                            until the memory accepts the request
//   mem_wen, mem_addr        registered copy of the granted request
//   mem_wdata, mem_mask      registered copy of the granted request
//   mem_resp_valid           memory response or write acknowledge
//   mem_rdata                memory read data
//
// Configuration
//   YSYX_22041211_ARB_TIMEOUT_EN
//     When this macro is defined, a WAIT that lasts TIMEOUT_CYCLES cycles
//     without mem_resp_valid completes with rdata = 32'hDEAD_BEEF and sets the
//     owner's resp_err flag.
//     When the macro is undefined, WAIT waits with no limit and both err
//     outputs are tied to 0.
// ============================================================================
module ysyx_22041211_mem_arbiter #(
    parameter int DATA_LEN       = 32,
    parameter int ADDR_LEN       = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_LEN-1:0] ifu_raddr,
    output logic                ifu_resp_valid,
    output logic [DATA_LEN-1:0] ifu_rdata,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic                lsu_wen,
    input  logic [ADDR_LEN-1:0] lsu_addr,
    input  logic [DATA_LEN-1:0] lsu_wdata,
    input  logic [7:0]          lsu_mask,
    output logic                lsu_resp_valid,
    output logic [DATA_LEN-1:0] lsu_rdata,
    output logic                lsu_resp_err,
    output logic                ifu_resp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_wen,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [DATA_LEN-1:0] mem_wdata,
    output logic [7:0]          mem_mask,
    input  logic                mem_resp_valid,
    input  logic [DATA_LEN-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam logic OWNER_IFU = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

    state_t                state_q,          state_d;
    logic                  owner_q,          owner_d;
    logic                  mem_req_valid_q,  mem_req_valid_d;
    logic                  mem_wen_q,        mem_wen_d;
    logic [ADDR_LEN-1:0]   mem_addr_q,       mem_addr_d;
    logic [DATA_LEN-1:0]   mem_wdata_q,      mem_wdata_d;
    logic [7:0]            mem_mask_q,       mem_mask_d;
    logic                  ifu_resp_valid_q, ifu_resp_valid_d;
    logic                  lsu_resp_valid_q, lsu_resp_valid_d;
    logic [DATA_LEN-1:0]   ifu_rdata_q,      ifu_rdata_d;
    logic [DATA_LEN-1:0]   lsu_rdata_q,      lsu_rdata_d;

    logic idle;
    logic resp_done;                // WAIT finishes this cycle
    logic [DATA_LEN-1:0] resp_data; // data routed to the owner's rdata register

    // The readies are gated by rst, so nothing can be accepted while the
    // arbiter is being reset.
    assign idle          = (state_q == IDLE) && !rst;
    assign lsu_req_ready = idle;
    assign ifu_req_ready = idle && !lsu_req_valid;

`ifdef YSYX_22041211_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_q,      tmo_cnt_d;
    logic             ifu_resp_err_q, ifu_resp_err_d;
    logic             lsu_resp_err_q, lsu_resp_err_d;
    logic             timed_out;

    assign timed_out = (state_q == WAIT) && !mem_resp_valid
                       && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES));
    assign resp_done = ((state_q == WAIT) && mem_resp_valid) || timed_out;
    assign resp_data = timed_out ? DATA_LEN'(32'hDEAD_BEEF)
                     : (mem_wen_q ? '0 : mem_rdata);

    always_comb begin
        tmo_cnt_d      = tmo_cnt_q;
        ifu_resp_err_d = ifu_resp_err_q;
        lsu_resp_err_d = lsu_resp_err_q;
        if (state_q == REQ) begin
            // Clear the counter on the way into WAIT.
            tmo_cnt_d = '0;
        end else if (state_q == WAIT && !resp_done) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
        // A normal response clears the owner's error flag. A timeout sets it.
        if (resp_done) begin
            if (owner_q == OWNER_LSU) lsu_resp_err_d = timed_out;
            else                      ifu_resp_err_d = timed_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q      <= '0;
            ifu_resp_err_q <= 1'b0;
            lsu_resp_err_q <= 1'b0;
        end else begin
            tmo_cnt_q      <= tmo_cnt_d;
            ifu_resp_err_q <= ifu_resp_err_d;
            lsu_resp_err_q <= lsu_resp_err_d;
        end
    end

    assign ifu_resp_err = ifu_resp_err_q;
    assign lsu_resp_err = lsu_resp_err_q;
`else
    assign resp_done    = (state_q == WAIT) && mem_resp_valid;
    assign resp_data    = mem_wen_q ? '0 : mem_rdata;
    assign ifu_resp_err = 1'b0;
    assign lsu_resp_err = 1'b0;
`endif

    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        mem_req_valid_d  = mem_req_valid_q;
        mem_wen_d        = mem_wen_q;
        mem_addr_d       = mem_addr_q;
        mem_wdata_d      = mem_wdata_q;
        mem_mask_d       = mem_mask_q;
        ifu_resp_valid_d = 1'b0;
        lsu_resp_valid_d = 1'b0;
        ifu_rdata_d      = ifu_rdata_q;
        lsu_rdata_d      = lsu_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (lsu_req_valid) begin
                    owner_d         = OWNER_LSU;
                    mem_wen_d       = lsu_wen;
                    mem_addr_d      = lsu_addr;
                    mem_wdata_d     = lsu_wdata;
                    mem_mask_d      = lsu_mask;
                    mem_req_valid_d = 1'b1;
                    state_d         = REQ;
                end else if (ifu_req_valid) begin
                    owner_d         = OWNER_IFU;
                    mem_wen_d       = 1'b0;
                    mem_addr_d      = ifu_raddr;
                    mem_wdata_d     = '0;
                    mem_mask_d      = 8'h0F;
                    mem_req_valid_d = 1'b1;
                    state_d         = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    state_d         = WAIT;
                end
            end
            WAIT: begin
                if (resp_done) begin
                    if (owner_q == OWNER_LSU) begin
                        lsu_rdata_d      = resp_data;
                        lsu_resp_valid_d = 1'b1;
                    end else begin
                        ifu_rdata_d      = resp_data;
                        ifu_resp_valid_d = 1'b1;
                    end
                    state_d = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            owner_q          <= OWNER_IFU;
            mem_req_valid_q  <= 1'b0;
            mem_wen_q        <= 1'b0;
            mem_addr_q       <= '0;
            mem_wdata_q      <= '0;
            mem_mask_q       <= '0;
            ifu_resp_valid_q <= 1'b0;
            lsu_resp_valid_q <= 1'b0;
            ifu_rdata_q      <= '0;
            lsu_rdata_q      <= '0;
        end else begin
            state_q          <= state_d;
            owner_q          <= owner_d;
            mem_req_valid_q  <= mem_req_valid_d;
            mem_wen_q        <= mem_wen_d;
            mem_addr_q       <= mem_addr_d;
            mem_wdata_q      <= mem_wdata_d;
            mem_mask_q       <= mem_mask_d;
            ifu_resp_valid_q <= ifu_resp_valid_d;
            lsu_resp_valid_q <= lsu_resp_valid_d;
            ifu_rdata_q      <= ifu_rdata_d;
            lsu_rdata_q      <= lsu_rdata_d;
        end
    end

    assign mem_req_valid  = mem_req_valid_q;
    assign mem_wen        = mem_wen_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_mask       = mem_mask_q;
    assign ifu_resp_valid = ifu_resp_valid_q;
    assign lsu_resp_valid = lsu_resp_valid_q;
    assign ifu_rdata      = ifu_rdata_q;
    assign lsu_rdata      = lsu_rdata_q;

endmodule

// File: tb/tb_ysyx_22041211_mem_arbiter.sv
// Directed testbench for ysyx_22041211_mem_arbiter.
// Inputs are driven 1 time unit after each rising edge. Outputs are checked
// 1 or 2 time units after the edge, well away from the next edge.
module tb_ysyx_22041211_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
    logic [31:0] ifu_raddr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_mask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_mask;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_22041211_mem_arbiter #(
        .DATA_LEN(32), .ADDR_LEN(32), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_raddr(ifu_raddr), .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_wen(lsu_wen), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_mask(lsu_mask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .lsu_resp_err(lsu_resp_err), .ifu_resp_err(ifu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---- 1. Reset with both valids high ----
        rst = 1'b1; ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        ifu_raddr = 32'h0; lsu_wen = 1'b0; lsu_addr = 32'h0; lsu_wdata = 32'h0;
        lsu_mask = 8'h0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0;
        for (int i = 0; i < 2; i++) begin
            next;
            check("rst_lsu_ready", lsu_req_ready, 1'b0);
            check("rst_ifu_ready", ifu_req_ready, 1'b0);
            check("rst_outs", {mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_mask,
                               ifu_resp_valid, lsu_resp_valid, ifu_rdata, lsu_rdata,
                               ifu_resp_err, lsu_resp_err}, 143'h0);
        end
        $display("txn reset done");
        rst = 1'b0; ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;

        // ---- 2. IFU read, minimum latency ----
        next;                                   // cycle N
        ifu_req_valid = 1'b1; ifu_raddr = 32'h8000_0000; mem_req_ready = 1'b1;
        #1 check("ifu_ready_idle", ifu_req_ready, 1'b1);
        next;                                   // N+1: REQ
        ifu_req_valid = 1'b0;
        check("ifu_mem_valid", mem_req_valid, 1'b1);
        check("ifu_mem_addr", mem_addr, 32'h8000_0000);
        check("ifu_mem_mask", mem_mask, 8'h0F);
        check("ifu_mem_wen", mem_wen, 1'b0);
        check("ifu_mem_wdata", mem_wdata, 32'h0);
        check("ifu_ready_busy", ifu_req_ready, 1'b0);
        next;                                   // N+2: WAIT
        check("ifu_mem_valid_drop", mem_req_valid, 1'b0);
        mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0413;
        next;                                   // N+3: RESP
        mem_resp_valid = 1'b0;
        check("ifu_resp_valid", ifu_resp_valid, 1'b1);
        check("ifu_rdata", ifu_rdata, 32'h0000_0413);
        check("ifu_resp_err", ifu_resp_err, 1'b0);
        check("ifu_no_lsu_resp", lsu_resp_valid, 1'b0);
        next;                                   // N+4: IDLE
        check("ifu_resp_pulse", ifu_resp_valid, 1'b0);
        check("idle_again", lsu_req_ready, 1'b1);
        $display("txn ifu_read addr=80000000 rdata=%08h", ifu_rdata);

        // ---- 3. Conflict: LSU wins, IFU follows ----
        lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_0100;
        lsu_wdata = 32'h0; lsu_mask = 8'h01;
        ifu_req_valid = 1'b1; ifu_raddr = 32'h8000_0004;
        #1 check("conf_ifu_ready", ifu_req_ready, 1'b0);
        check("conf_lsu_ready", lsu_req_ready, 1'b1);
        next;
        lsu_req_valid = 1'b0;
        check("conf_lsu_addr", mem_addr, 32'h8000_0100);
        check("conf_lsu_mask", mem_mask, 8'h01);
        check("conf_ifu_wait", ifu_req_ready, 1'b0);
        next;
        mem_resp_valid = 1'b1; mem_rdata = 32'h0000_00AB;
        next;
        mem_resp_valid = 1'b0;
        check("conf_lsu_resp", lsu_resp_valid, 1'b1);
        check("conf_lsu_rdata", lsu_rdata, 32'h0000_00AB);
        check("conf_ifu_not_yet", ifu_resp_valid, 1'b0);
        next;                                   // IDLE: IFU granted now
        #1 check("conf_ifu_grant", ifu_req_ready, 1'b1);
        next;
        ifu_req_valid = 1'b0;
        check("conf_ifu_addr", mem_addr, 32'h8000_0004);
        check("conf_ifu_mask", mem_mask, 8'h0F);
        next;
        mem_resp_valid = 1'b1; mem_rdata = 32'h0010_0093;
        next;
        mem_resp_valid = 1'b0;
        check("conf_ifu_resp", ifu_resp_valid, 1'b1);
        check("conf_ifu_rdata", ifu_rdata, 32'h0010_0093);
        check("conf_lsu_hold", lsu_rdata, 32'h0000_00AB);
        next;
        $display("txn conflict lsu=%08h ifu=%08h", lsu_rdata, ifu_rdata);

        // ---- 4. Store with memory backpressure ----
        mem_req_ready = 1'b0;
        lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_0200;
        lsu_wdata = 32'h1234_5678; lsu_mask = 8'h0F;
        next;
        lsu_req_valid = 1'b0; lsu_addr = 32'hFFFF_FFF0; lsu_wdata = 32'hCAFE_F00D;
        lsu_mask = 8'h01; lsu_wen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("st_valid", mem_req_valid, 1'b1);
            check("st_addr", mem_addr, 32'h8000_0200);
            check("st_wdata", mem_wdata, 32'h1234_5678);
            check("st_wen_mask", {mem_wen, mem_mask}, 9'h10F);
            if (i == 3) mem_req_ready = 1'b1;
            next;
        end
        mem_resp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        next;
        mem_resp_valid = 1'b0;
        check("st_resp", lsu_resp_valid, 1'b1);
        check("st_rdata_zero", lsu_rdata, 32'h0);
        next;
        $display("txn store addr=80000200 lsu_rdata=%08h", lsu_rdata);

        // ---- 5. Reset in WAIT, then a late response ----
        ifu_req_valid = 1'b1; ifu_raddr = 32'h8000_0008;
        next;                                   // REQ
        ifu_req_valid = 1'b0;
        next;                                   // WAIT
        rst = 1'b1;
        next;                                   // reset applied
        rst = 1'b0;
        check("mr_mem_valid", mem_req_valid, 1'b0);
        check("mr_mem_addr", mem_addr, 32'h0);
        next;
        mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0055;
        next;
        mem_resp_valid = 1'b0;
        check("mr_no_ifu_resp", ifu_resp_valid, 1'b0);
        check("mr_no_lsu_resp", lsu_resp_valid, 1'b0);
        check("mr_ifu_rdata", ifu_rdata, 32'h0);
        check("mr_idle", lsu_req_ready, 1'b1);
        next;
        check("mr_no_resp_later", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
        $display("txn midflight_reset ifu_resp=%0b lsu_resp=%0b", ifu_resp_valid, lsu_resp_valid);

`ifdef YSYX_22041211_ARB_TIMEOUT_EN
        // ---- 6. Timeout with TIMEOUT_CYCLES=4 ----
        lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_0300; lsu_mask = 8'h0F;
        next;                                   // REQ
        lsu_req_valid = 1'b0;
        next;                                   // first WAIT cycle
        for (int i = 0; i < 5; i++) begin
            check("tmo_no_resp", lsu_resp_valid, 1'b0);
            next;
        end
        check("tmo_resp", lsu_resp_valid, 1'b1);
        check("tmo_rdata", lsu_rdata, 32'hDEAD_BEEF);
        check("tmo_err", lsu_resp_err, 1'b1);
        next;
        $display("txn timeout rdata=%08h err=%0b", lsu_rdata, lsu_resp_err);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
